// File: rtl/bus_a_src_drv.sv
// Source-side driver for the A-bus OR-combiner: latches a select code, registers a one-hot
// source enable and gates each source lane so at most one lane toward the bus is non-zero.
module bus_a_src_drv #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NSRC  = 9,
  parameter int unsigned SELW  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sel_valid,
  input  logic [SELW-1:0]       sel,
  output logic                  sel_ready,
  input  logic                  hold,
  input  logic                  clr_err,
  input  logic [NSRC*WIDTH-1:0] src_data,
  output logic [NSRC*WIDTH-1:0] drv_out,
  output logic [NSRC-1:0]       src_en,
  output logic                  drv_valid,
  output logic                  sel_err
);

  typedef enum logic [0:0] {StIdle, StDrive} state_e;

  state_e            state_q, state_d;
  logic [NSRC-1:0]   en_q, en_d;
  logic              err_q, err_d;
  logic              accept;
  logic              sel_legal;
  logic              sel_none;

  assign accept    = sel_valid & ~hold;
  assign sel_legal = (sel < SELW'(NSRC));
  assign sel_none  = (sel == {SELW{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      en_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    // Sticky error: a new illegal accept below overrides a simultaneous clear.
    err_d   = err_q & ~clr_err;
    if (accept) begin
      if (sel_legal) begin
        state_d = StDrive;
        for (int unsigned i = 0; i < NSRC; i++) begin
          en_d[i] = (sel == SELW'(i));
        end
      end else if (sel_none) begin
        state_d = StDrive;
        en_d    = '0;
      end else begin
        state_d = StIdle;
        en_d    = '0;
        err_d   = 1'b1;
      end
    end else if (!hold) begin
      state_d = StIdle;
      en_d    = '0;
    end
  end

  always_comb begin
    sel_ready = ~hold;
    drv_valid = (state_q == StDrive);
    src_en    = (state_q == StDrive) ? en_q : '0;
    sel_err   = err_q;
    drv_out   = '0;
    // Gate from the registered enable so live source changes pass straight through.
    for (int unsigned i = 0; i < NSRC; i++) begin
      drv_out[i*WIDTH +: WIDTH] = src_data[i*WIDTH +: WIDTH] & {WIDTH{src_en[i]}};
    end
  end

endmodule

// File: tb/tb_bus_a_src_drv.sv
// Directed and random self-checking bench for bus_a_src_drv.
module tb_bus_a_src_drv;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned NSRC  = 9;
  localparam int unsigned SELW  = 4;
  localparam int unsigned TOTW  = NSRC * WIDTH;

  logic             clk;
  logic             rst_n;
  logic             sel_valid;
  logic [SELW-1:0]  sel;
  logic             sel_ready;
  logic             hold;
  logic             clr_err;
  logic [TOTW-1:0]  src_data;
  logic [TOTW-1:0]  drv_out;
  logic [NSRC-1:0]  src_en;
  logic             drv_valid;
  logic             sel_err;

  int vectors;
  int miscompares;

  bus_a_src_drv #(
    .WIDTH (WIDTH),
    .NSRC  (NSRC),
    .SELW  (SELW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sel_valid (sel_valid),
    .sel       (sel),
    .sel_ready (sel_ready),
    .hold      (hold),
    .clr_err   (clr_err),
    .src_data  (src_data),
    .drv_out   (drv_out),
    .src_en    (src_en),
    .drv_valid (drv_valid),
    .sel_err   (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      assert ($countones(src_en) <= 1)
        else $error("one-hot invariant violated: src_en=%b", src_en);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [TOTW-1:0] fill_lanes(input logic [WIDTH-1:0] w);
    logic [TOTW-1:0] v;
    for (int i = 0; i < NSRC; i++) v[i*WIDTH +: WIDTH] = w;
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; sel_valid = 1'b0; sel = '0; hold = 1'b0; clr_err = 1'b0;
    src_data = fill_lanes(16'hFFFF);
    #3;
    vectors++;
    if (src_en !== 9'h000 || drv_valid !== 1'b0 || sel_err !== 1'b0 || drv_out !== '0) begin
      miscompares++;
      $display("FAIL reset_state: src_en=%h drv_valid=%b sel_err=%b drv_out=%h, want 000 0 0 0",
               src_en, drv_valid, sel_err, drv_out);
    end
    vectors++;
    if (sel_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: sel_ready=%b want 1", sel_ready);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_legal();
    logic [TOTW-1:0] exp;
    src_data = fill_lanes(16'hFFFF);
    src_data[5*WIDTH +: WIDTH] = 16'hA5C3;
    sel_valid = 1'b1; sel = 4'd5;
    tick();
    sel_valid = 1'b0;
    exp = '0;
    exp[5*WIDTH +: WIDTH] = 16'hA5C3;
    vectors++;
    if (src_en !== 9'b000100000 || drv_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL legal_en: src_en=%b drv_valid=%b want 000100000 1", src_en, drv_valid);
    end
    vectors++;
    if (drv_out !== exp) begin
      miscompares++;
      $display("FAIL legal_drv: drv_out=%h want %h", drv_out, exp);
    end
    // Live source change propagates within the cycle.
    src_data[5*WIDTH +: WIDTH] = 16'h1234;
    src_data[4*WIDTH +: WIDTH] = 16'h0F0F;
    #1;
    exp[5*WIDTH +: WIDTH] = 16'h1234;
    vectors++;
    if (drv_out !== exp) begin
      miscompares++;
      $display("FAIL legal_live: drv_out=%h want %h", drv_out, exp);
    end
    tick();
    vectors++;
    if (src_en !== '0 || drv_valid !== 1'b0 || drv_out !== '0) begin
      miscompares++;
      $display("FAIL legal_idle: src_en=%b drv_valid=%b drv_out=%h want 0 0 0",
               src_en, drv_valid, drv_out);
    end
  endtask

  task automatic test_back_to_back();
    src_data = fill_lanes(16'h5A5A);
    sel_valid = 1'b1; sel = 4'd0;
    tick();
    vectors++;
    if (src_en !== 9'h001 || drv_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_first: src_en=%h drv_valid=%b want 001 1", src_en, drv_valid);
    end
    sel = 4'd8;
    tick();
    vectors++;
    if (src_en !== 9'h100 || drv_valid !== 1'b1 || drv_out[8*WIDTH +: WIDTH] !== 16'h5A5A) begin
      miscompares++;
      $display("FAIL b2b_second: src_en=%h drv_valid=%b lane8=%h want 100 1 5a5a",
               src_en, drv_valid, drv_out[8*WIDTH +: WIDTH]);
    end
    hold = 1'b1; sel = 4'd2;
    #1;
    vectors++;
    if (sel_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_ready: sel_ready=%b want 0", sel_ready);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if (src_en !== 9'h100 || drv_valid !== 1'b1 || sel_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_cycle%0d: src_en=%h drv_valid=%b sel_ready=%b want 100 1 0",
                 c, src_en, drv_valid, sel_ready);
      end
    end
    hold = 1'b0; sel_valid = 1'b0;
    tick();
    vectors++;
    if (src_en !== '0 || drv_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_release: src_en=%h drv_valid=%b want 000 0", src_en, drv_valid);
    end
  endtask

  task automatic test_no_source();
    src_data = fill_lanes(16'hFFFF);
    sel_valid = 1'b1; sel = 4'hF;
    tick();
    sel_valid = 1'b0;
    vectors++;
    if (drv_valid !== 1'b1 || src_en !== '0 || drv_out !== '0) begin
      miscompares++;
      $display("FAIL no_source: drv_valid=%b src_en=%h drv_out=%h want 1 000 0",
               drv_valid, src_en, drv_out);
    end
    tick();
    vectors++;
    if (drv_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL no_source_idle: drv_valid=%b want 0", drv_valid);
    end
  endtask

  task automatic test_illegal();
    sel_valid = 1'b1; sel = 4'd1;
    tick();
    vectors++;
    if (src_en !== 9'h002 || sel_err !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_pre: src_en=%h sel_err=%b want 002 0", src_en, sel_err);
    end
    sel = 4'd9;
    tick();
    vectors++;
    if (sel_err !== 1'b1 || drv_valid !== 1'b0 || src_en !== '0 || drv_out !== '0) begin
      miscompares++;
      $display("FAIL illegal_9: sel_err=%b drv_valid=%b src_en=%h drv_out=%h want 1 0 000 0",
               sel_err, drv_valid, src_en, drv_out);
    end
    sel = 4'd12; clr_err = 1'b1;
    tick();
    vectors++;
    if (sel_err !== 1'b1) begin
      miscompares++;
      $display("FAIL illegal_set_wins: sel_err=%b want 1", sel_err);
    end
    sel_valid = 1'b0;
    tick();
    clr_err = 1'b0;
    vectors++;
    if (sel_err !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_clear: sel_err=%b want 0", sel_err);
    end
    sel_valid = 1'b1; sel = 4'hE;
    tick();
    sel_valid = 1'b0;
    vectors++;
    if (sel_err !== 1'b1 || drv_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_14: sel_err=%b drv_valid=%b want 1 0", sel_err, drv_valid);
    end
    tick();
    vectors++;
    if (sel_err !== 1'b1) begin
      miscompares++;
      $display("FAIL illegal_sticky: sel_err=%b want 1", sel_err);
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  task automatic test_reset_mid_drive();
    src_data = fill_lanes(16'hC0DE);
    sel_valid = 1'b1; sel = 4'd3;
    tick();
    sel_valid = 1'b0;
    vectors++;
    if (src_en !== 9'h008) begin
      miscompares++;
      $display("FAIL rst_mid_pre: src_en=%h want 008", src_en);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (src_en !== '0 || drv_out !== '0 || drv_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_async: src_en=%h drv_valid=%b drv_out=%h want 000 0 0",
               src_en, drv_valid, drv_out);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [NSRC-1:0]  exp_en;
    logic             exp_valid;
    logic             exp_err;
    logic [NSRC-1:0]  n_en;
    logic             n_valid;
    logic             n_err;
    logic             acc;
    logic [WIDTH-1:0] or_lanes;
    logic [WIDTH-1:0] exp_word;
    exp_en = '0; exp_valid = 1'b0; exp_err = sel_err;
    for (int c = 0; c < 2000; c++) begin
      sel_valid = ($urandom_range(0, 3) != 0);
      sel       = SELW'($urandom_range(0, 15));
      hold      = ($urandom_range(0, 4) == 0);
      clr_err   = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < NSRC; i++) src_data[i*WIDTH +: WIDTH] = WIDTH'($urandom());
      acc   = sel_valid && !hold;
      n_err = clr_err ? 1'b0 : exp_err;
      if (acc) begin
        if (sel < 4'd9) begin
          n_en = 9'b1 << sel; n_valid = 1'b1;
        end else if (sel == 4'hF) begin
          n_en = '0; n_valid = 1'b1;
        end else begin
          n_en = '0; n_valid = 1'b0; n_err = 1'b1;
        end
      end else if (hold) begin
        n_en = exp_en; n_valid = exp_valid;
      end else begin
        n_en = '0; n_valid = 1'b0;
      end
      tick();
      exp_en = n_en; exp_valid = n_valid; exp_err = n_err;
      vectors++;
      if (src_en !== exp_en || drv_valid !== exp_valid || sel_err !== exp_err) begin
        miscompares++;
        $display("FAIL rand_state c%0d: src_en=%h drv_valid=%b sel_err=%b want %h %b %b",
                 c, src_en, drv_valid, sel_err, exp_en, exp_valid, exp_err);
      end
      vectors++;
      if ($countones(src_en) > 1) begin
        miscompares++;
        $display("FAIL rand_onehot c%0d: src_en=%b", c, src_en);
      end
      or_lanes = '0;
      exp_word = '0;
      for (int i = 0; i < NSRC; i++) begin
        or_lanes = or_lanes | drv_out[i*WIDTH +: WIDTH];
        if (exp_en[i]) exp_word = src_data[i*WIDTH +: WIDTH];
      end
      vectors++;
      if (or_lanes !== exp_word) begin
        miscompares++;
        $display("FAIL rand_or c%0d: or_lanes=%h want %h", c, or_lanes, exp_word);
      end
    end
    sel_valid = 1'b0; hold = 1'b0; clr_err = 1'b0;
    tick();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_legal();
    test_back_to_back();
    test_no_source();
    test_illegal();
    test_reset_mid_drive();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_a_src_drv.md
Name: bus_a_src_drv

Overview:
- Source-side driver for the A-bus OR-combiner.
- Latches a source-select code from the control unit and produces a registered one-hot source enable.
- Presents each of the 9 source words gated by its enable, so at most one lane is non-zero.
- The 9 drv_out lanes connect directly to the A-bus in0..in8. The block guarantees a clean OR (no contention) and flags illegal select codes.

Parameters:
- WIDTH, 16, data width of each source/bus lane
- NSRC, 9, number of bus sources (select codes 0..NSRC-1 legal)
- SELW, 4, width of select code

Ports:
- clk  in  1  system clock, rising-edge
- rst_n  in  1  asynchronous, active-low reset
- sel_valid  in  1  control unit offers a select code this cycle
- sel  in  SELW  source select; 0..NSRC-1 = source index, all-ones = "no source" (bus reads 0), others illegal
- sel_ready  out  1  block accepts a select this cycle
- hold  in  1  stall: keep current drive, refuse new selects
- clr_err  in  1  clears sel_err
- src_data  in  NSRC*WIDTH  flattened source words, lane i = bits [i*WIDTH +: WIDTH]
- drv_out  out  NSRC*WIDTH  gated lanes to A-bus in0..in(NSRC-1)
- src_en  out  NSRC  registered one-hot (or zero) enable
- drv_valid  out  1  bus content is a committed drive this cycle
- sel_err  out  1  sticky illegal-select flag

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-drive): state=IDLE, src_en=0, drv_valid=0, sel_err=0. drv_out is therefore all-zero immediately.
- FSM states:
  - IDLE: src_en=0, drv_valid=0.
  - DRIVE: src_en holds the latched enable, drv_valid=1.
- sel_ready = ~hold, combinational, in both states.
- Accept = sel_valid & sel_ready, sampled at the rising edge.
- Accept with legal index k (k<NSRC): next src_en = 1<<k, next state DRIVE. Latency is 1 cycle: src_en/drv_valid are valid in the cycle after acceptance.
- Accept with sel = all-ones: next src_en = 0, state DRIVE, drv_valid=1. The bus carries 0 as a valid value.
- Accept with illegal code (NSRC..2^SELW-2): sel_err<=1, next state IDLE, src_en<=0. A legal drive in progress is dropped.
- DRIVE, no accept, hold=0: return to IDLE next cycle (single-cycle drive).
- DRIVE, hold=1: remain in DRIVE, src_en unchanged, sel ignored.
- IDLE, hold=1: remain IDLE.
- Back-to-back: an accept while in DRIVE replaces src_en at the next edge with no IDLE bubble.
- drv_out lane i = src_data lane i AND replicate(src_en[i]).
  - Combinational from the registered enable: live source changes propagate within the same cycle.
  - Non-selected lanes are exactly 0.
- Invariant: popcount(src_en) <= 1 in every cycle. Assertion required in verification.
- sel_err is sticky.
  - clr_err=1 clears it at the next edge.
  - Simultaneous clr_err and illegal accept: set wins (sel_err stays 1).
- No arithmetic. Widths are fixed by parameters; flattened indexing must be exact for NSRC*WIDTH bits.

Test Plan:
- Reset mid-drive: accept sel=3, then pull rst_n low between edges -> src_en=0, drv_out=0, drv_valid=0 immediately, without waiting for a clock edge.
- Legal select:
  - Stimulus: src_data lane 5 = 16'hA5C3, all other lanes = 16'hFFFF; accept sel=5.
  - Next cycle: src_en=9'b000100000, lane 5 of drv_out=16'hA5C3, all other lanes 0, drv_valid=1.
  - Following cycle (no accept): IDLE, all outputs 0.
- Back-to-back and hold:
  - Accept sel=0, then sel=8 on the next cycle -> src_en goes 0x001 then 0x100 with no gap.
  - Assert hold for 3 cycles with sel_valid=1, sel=2 -> src_en stays 0x100, sel_ready=0.
- No-source: accept sel=4'hF -> drv_valid=1, src_en=0, all drv_out lanes 0.
- Illegal select: accept sel=9 while driving sel=1 -> next cycle sel_err=1, IDLE, src_en=0.
  - Assert clr_err together with another accept of sel=12 -> sel_err stays 1.
  - clr_err alone -> sel_err=0.
- Random regression: 2000 cycles of random sel/sel_valid/hold/src_data.
  - Check the one-hot invariant every cycle.
  - OR of all drv_out lanes equals the selected source word.
